// File: rtl/chs_temp_controller.sv
// chs_temp_controller: 4-sample moving-average temperature filter that feeds
// the cool/heat stage, plus a slew-limited fan speed derived from setpoint error.
//
// Ports:
//   clk          in   1  clock, posedge
//   arst         in   1  asynchronous active-high reset
//   sample       in   8  raw temperature (degrees, unsigned)
//   sample_valid in   1  accept sample on this edge
//   setpoint     in   8  desired temperature (degrees)
//   chs_conf     out  8  filtered temperature (registered)
//   conf_valid   out  1  filter window full
//   speed        out  8  fan duty-cycle (registered, slew-limited)
module chs_temp_controller #(
    parameter int GAIN     = 8,
    parameter int DEADBAND = 2,
    parameter int STEP     = 1,
    parameter int RAMP_DIV = 16
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] sample,
    input  logic       sample_valid,
    input  logic [7:0] setpoint,
    output logic [7:0] chs_conf,
    output logic       conf_valid,
    output logic [7:0] speed
);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [0:0]    r_state;
    logic [2:0]    r_cnt;
    logic [7:0]    r_buf [4];
    logic [1:0]    r_wptr;
    logic [9:0]    r_sum;
    logic          r_acc;
    logic [7:0]    r_conf;
    logic          r_valid;
    logic [7:0]    r_speed;
    logic [PW-1:0] r_pre;

    logic [9:0]  w_sum_nxt;
    logic [7:0]  w_err;
    logic [15:0] w_prod;
    logic [7:0]  w_target;
    logic        w_tick;
    logic [15:0] w_up;
    logic [7:0]  w_gap;
    logic [7:0]  w_speed_nxt;

    // Buffer starts at zero, so subtracting the oldest entry keeps the sum exact while filling.
    assign w_sum_nxt = r_sum + {2'b00, sample} - {2'b00, r_buf[r_wptr]};

    // Filter datapath and fill/run state
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= S_FILL;
            r_cnt   <= 3'd0;
            r_wptr  <= 2'd0;
            r_sum   <= 10'd0;
            r_acc   <= 1'b0;
            r_conf  <= 8'd0;
            r_valid <= 1'b0;
            for (int i = 0; i < 4; i++) r_buf[i] <= 8'd0;
        end else begin
            r_acc <= sample_valid;
            if (sample_valid) begin
                r_buf[r_wptr] <= sample;
                r_wptr        <= r_wptr + 2'd1;
                r_sum         <= w_sum_nxt;
                if (r_state == S_FILL) begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd3) r_state <= S_RUN;
                end
            end
            // Output follows the accept by one cycle, using the sum it produced.
            if (r_acc && r_state == S_RUN) begin
                r_conf  <= r_sum[9:2];
                r_valid <= 1'b1;
            end
        end
    end

    // Target speed from filtered error
    always_comb begin
        w_err = (r_conf >= setpoint) ? (r_conf - setpoint) : (setpoint - r_conf);
        w_prod = {8'd0, w_err} * 16'(GAIN);
        if (!r_valid || int'(w_err) <= DEADBAND)
            w_target = 8'd0;
        else if (w_prod > 16'd255)
            w_target = 8'd255;
        else
            w_target = w_prod[7:0];
    end

    assign w_tick = (r_pre == PW'(RAMP_DIV - 1));

    // Slew step toward target, clamped at target to avoid overshoot and wrap
    always_comb begin
        w_up        = {8'd0, r_speed} + 16'(STEP);
        w_gap       = r_speed - w_target;
        w_speed_nxt = r_speed;
        if (r_speed < w_target) begin
            if (w_up > {8'd0, w_target}) w_speed_nxt = w_target;
            else                         w_speed_nxt = w_up[7:0];
        end else if (r_speed > w_target) begin
            if ({8'd0, w_gap} > 16'(STEP)) w_speed_nxt = r_speed - 8'(STEP);
            else                           w_speed_nxt = w_target;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_pre   <= '0;
            r_speed <= 8'd0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            if (w_tick) r_speed <= w_speed_nxt;
        end
    end

    assign chs_conf   = r_conf;
    assign conf_valid = r_valid;
    assign speed      = r_speed;

endmodule

// File: tb/tb_chs_temp_controller.sv
// tb_chs_temp_controller: vector table, directed corner sequences and random
// stimulus checked against a window/queue reference model of the controller.
module tb_chs_temp_controller;

    localparam int GAIN = 8, DB = 2, STEP = 1, RDIV = 16;

    logic       clk = 0;
    logic       arst = 1;
    logic [7:0] sample = 0;
    logic       sample_valid = 0;
    logic [7:0] setpoint = 0;
    logic [7:0] chs_conf, chs_conf2;
    logic       conf_valid, conf_valid2;
    logic [7:0] speed, speed2;

    int total = 0;
    int bad = 0;

    chs_temp_controller u_dut (
        .clk(clk), .arst(arst), .sample(sample), .sample_valid(sample_valid),
        .setpoint(setpoint), .chs_conf(chs_conf), .conf_valid(conf_valid), .speed(speed)
    );

    chs_temp_controller #(.GAIN(5), .DEADBAND(1), .STEP(7), .RAMP_DIV(1)) u_dut2 (
        .clk(clk), .arst(arst), .sample(sample), .sample_valid(sample_valid),
        .setpoint(setpoint), .chs_conf(chs_conf2), .conf_valid(conf_valid2), .speed(speed2)
    );

    always #5 clk = ~clk;

    // Reference model: queue of accepted samples and plain arithmetic
    int m_win[$];
    int m_acc, m_conf, m_valid, m_speed, m_cyc, m_pend;

    typedef struct {
        int s0, s1, s2, s3;
        int exp_conf;
    } vec_t;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tgt(int conf, int valid, int sp);
        int e, p;
        e = (conf > sp) ? conf - sp : sp - conf;
        p = e * GAIN;
        if (valid == 0 || e <= DB) return 0;
        return (p > 255) ? 255 : p;
    endfunction

    task automatic model_reset();
        m_win.delete();
        m_acc = 0; m_conf = 0; m_valid = 0;
        m_speed = 0; m_cyc = 0; m_pend = 0;
    endtask

    task automatic do_reset();
        arst = 1;
        model_reset();
        #1;
        check("rst_conf", int'(chs_conf), 0);
        check("rst_valid", int'(conf_valid), 0);
        check("rst_speed", int'(speed), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        arst = 0;
    endtask

    // One clock: apply inputs, advance model, compare after the edge
    task automatic cyc(input int v, input int s, input int sp);
        int t, nconf, nvalid, sum;
        sample_valid = v[0];
        sample = 8'(s);
        setpoint = 8'(sp);
        t = tgt(m_conf, m_valid, sp);
        if ((m_cyc % RDIV) == RDIV - 1) begin
            if (m_speed < t) m_speed = (m_speed + STEP > t) ? t : m_speed + STEP;
            else if (m_speed > t) m_speed = (m_speed - STEP < t) ? t : m_speed - STEP;
        end
        nconf = m_conf;
        nvalid = m_valid;
        if (m_pend != 0 && m_acc >= 4) begin
            sum = 0;
            foreach (m_win[i]) sum += m_win[i];
            nconf = sum / 4;
            nvalid = 1;
        end
        m_conf = nconf;
        m_valid = nvalid;
        if (v != 0) begin
            m_win.push_back(s);
            if (m_win.size() > 4) void'(m_win.pop_front());
            m_acc++;
        end
        m_pend = v;
        m_cyc++;
        @(posedge clk); #1;
        check("m_conf", int'(chs_conf), m_conf);
        check("m_valid", int'(conf_valid), m_valid);
        check("m_speed", int'(speed), m_speed);
    endtask

    vec_t vt[5];
    int sp, s;

    initial begin
        vt[0] = '{100, 100, 104, 108, 103};
        vt[1] = '{0, 0, 0, 3, 0};
        vt[2] = '{255, 255, 255, 255, 255};
        vt[3] = '{1, 2, 3, 4, 2};
        vt[4] = '{10, 20, 30, 41, 25};

        model_reset();
        #2;
        do_reset();

        // Fill/average vectors
        for (int i = 0; i < 5; i++) begin
            do_reset();
            cyc(1, vt[i].s0, 0);
            cyc(1, vt[i].s1, 0);
            cyc(1, vt[i].s2, 0);
            check("fill_valid_lo", int'(conf_valid), 0);
            cyc(1, vt[i].s3, 0);
            check("fill_conf_hold", int'(chs_conf), 0);
            cyc(0, 0, 0);
            check("fill_valid", int'(conf_valid), 1);
            check("fill_avg", int'(chs_conf), vt[i].exp_conf);
        end

        // Fifth sample slides the window
        do_reset();
        cyc(1, 100, 0); cyc(1, 100, 0); cyc(1, 104, 0); cyc(1, 108, 0);
        cyc(1, 120, 0);
        check("avg4", int'(chs_conf), 103);
        cyc(0, 0, 0);
        check("avg5", int'(chs_conf), 108);

        // Ramp up to 80 and hold
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 100, 90);
        for (int i = 0; i < 1400; i++) cyc(0, 0, 90);
        check("ramp_80", int'(speed), 80);
        for (int i = 0; i < 64; i++) cyc(0, 0, 90);
        check("ramp_hold", int'(speed), 80);

        // Saturation then ramp down to zero through deadband
        for (int i = 0; i < 4; i++) cyc(1, 150, 100);
        for (int i = 0; i < 3000; i++) cyc(0, 0, 100);
        check("sat_255", int'(speed), 255);
        for (int i = 0; i < 4200; i++) cyc(0, 0, 149);
        check("down_0", int'(speed), 0);
        for (int i = 0; i < 48; i++) cyc(0, 0, 150);
        check("eq_0", int'(speed), 0);

        // Reset mid-ramp at speed 40; sample_valid ignored during reset
        for (int i = 0; i < 1000 && m_speed != 40; i++) cyc(0, 0, 100);
        check("pre_rst_40", int'(speed), 40);
        sample_valid = 1;
        sample = 8'd200;
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 100, 100);
        cyc(0, 0, 100);
        check("post_rst_valid", int'(conf_valid), 0);
        check("post_rst_conf", int'(chs_conf), 0);

        // Deadband edges; second instance checks STEP clamp and RAMP_DIV=1
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 100, 98);
        cyc(0, 0, 98);
        check("s2_0", int'(speed2), 0);
        cyc(0, 0, 98);
        check("s2_7", int'(speed2), 7);
        cyc(0, 0, 98);
        check("s2_10", int'(speed2), 10);
        cyc(0, 0, 98);
        check("s2_hold", int'(speed2), 10);
        for (int i = 0; i < 100; i++) cyc(0, 0, 98);
        check("db_err2", int'(speed), 0);
        for (int i = 0; i < 500; i++) cyc(0, 0, 97);
        check("db_err3", int'(speed), 24);
        check("s2_err3", int'(speed2), 15);

        // Random traffic against the model
        do_reset();
        sp = 128;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 63) == 0) sp = $urandom_range(40, 215);
            s = sp + $urandom_range(0, 40) - 20;
            if ($urandom_range(0, 7) == 0) s = $urandom_range(0, 255);
            if ($urandom_range(0, 1999) == 0) do_reset();
            cyc($urandom_range(0, 1), s, sp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chs_temp_controller.md
# chs_temp_controller

Closed-loop front end for the cool/heat subsystem. It accepts raw 8-bit temperature samples, smooths them with a 4-sample moving average, and presents the result as the `chs_conf` degree value consumed by the cool/heat stage. It also derives a fan duty-cycle `speed` from the distance between the filtered temperature and a setpoint, slew-limited so the PWM fan stage never sees step changes.

## Interface
Parameters:
- `GAIN`, default 8: speed units per degree of error.
- `DEADBAND`, default 2: error (degrees) at or below which the speed target is 0.
- `STEP`, default 1: maximum speed change per ramp tick, must be ≥1.
- `RAMP_DIV`, default 16: clock cycles per ramp tick, must be ≥1.

Ports:
- `clk`, input, 1: clock, posedge.
- `arst`, input, 1: reset, asynchronous, active-high.
- `sample`, input, 8: raw temperature in degrees, unsigned.
- `sample_valid`, input, 1: `sample` is accepted on any posedge where this is high.
- `setpoint`, input, 8: desired temperature in degrees, unsigned, level-sampled every cycle.
- `chs_conf`, output, 8: filtered temperature, registered, drives the cool/heat stage.
- `conf_valid`, output, 1: high once the filter window is full.
- `speed`, output, 8: fan duty-cycle, registered, drives the fan PWM stage.

## Operation
- State machine states:
  - FILL: the reset state. Accepted samples are counted 0→4. On the 4th accepted sample, go to RUN.
  - RUN: steady state, left only by reset.
- Filter:
  - 4-entry circular buffer with a 2-bit write pointer that wraps 3→0.
  - 10-bit running sum is updated on each accept as `sum = sum + sample − buf[wptr]`.
  - Buffer entries reset to 0, so the sum is exact during FILL.
  - The average is `sum[9:2]`, which truncates.
- `chs_conf` loads the average one cycle after each accept, but only in RUN or on the transition into RUN. In FILL it holds 0.
- Error and target speed:
  - `err = |chs_conf − setpoint|`, 8-bit unsigned.
  - `prod = err × GAIN`, computed at 16-bit width.
  - `target = 0` if `conf_valid` is 0 or `err ≤ DEADBAND`; otherwise `min(prod, 255)`.
- Ramp:
  - A prescaler counts 0..RAMP_DIV−1 and wraps.
  - A tick occurs on the cycle the count is RAMP_DIV−1.
  - On a tick, if `speed < target`: `speed ← min(speed+STEP, target)`.
  - On a tick, if `speed > target`: `speed ← max(speed−STEP, target)`.
  - No overshoot and no 8-bit wrap in either direction.
  - Between ticks, `speed` holds.
- The prescaler runs freely from reset and is not restarted by target changes.

## Timing
- Reset values, applied immediately on `arst`:
  - `chs_conf` = 0, `conf_valid` = 0, `speed` = 0.
  - State = FILL, sample count = 0, `wptr` = 0, sum = 0, buffer = 0, prescaler = 0.
- Sample latency:
  - Sample accepted at edge N updates the sum at edge N.
  - `chs_conf` and `conf_valid` update at edge N+1.
  - `conf_valid` rises at edge N+1 of the 4th accept and stays high until reset.
- Back-to-back `sample_valid` on every cycle is supported, with one accept per cycle and no stall.
- Throughput: the filter output tracks every accept in RUN.
- `target` is combinational from registered `chs_conf` and the current `setpoint`. A setpoint change therefore affects `speed` at the next tick edge.
- An `err` of 0 with `DEADBAND` ≥ 0 always gives `target` 0.
- Boundary conditions:
  - `setpoint` equals `chs_conf`: `speed` ramps to 0.
  - 255 − 0 error with GAIN 8 (product 2040): clamps to 255.
  - Reset asserted mid-ramp or mid-FILL: all state returns to reset values with no partial output. Operation restarts in FILL after release.
  - `sample_valid` is ignored while `arst` is high.

## Test plan
- Reset: assert `arst` mid-operation with `speed` at 40 → `chs_conf`=0, `conf_valid`=0 and `speed`=0 asynchronously. After release, three samples of 100 leave `conf_valid`=0 and `chs_conf`=0.
- Fill and average: samples 100, 100, 104, 108 back-to-back → `conf_valid`=1 and `chs_conf`=103 one cycle after the 4th sample. A 5th sample of 120 gives `chs_conf`=108.
- Ramp up: filtered 100, `setpoint`=90 → `target`=80. `speed` increments by 1 every 16 cycles and reaches 80 after 80 ticks, then holds with no overshoot.
- Saturation and ramp down: filtered 150, `setpoint`=100 → `target`=255 (product 400 clamped). Then `setpoint`=149 (err 1 ≤ DEADBAND) → `target`=0, and `speed` decrements by STEP per tick to 0 without wrapping.
- Deadband edges: err=2 → `target`=0. err=3 → `target`=24.
- STEP rounding: STEP=7, `target`=10 from `speed` 0 → `speed` goes 7 then 10. RAMP_DIV=1 → a tick every cycle.
